// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - prescaled down-counting timer with one-shot/periodic modes and sticky irq
// Commands are resolved in one comb process (stop > start > pause); every output is a flop or a state decode.
module timer_ctrl #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   pause_i,
  input  logic                   mode_i,
  input  logic [WIDTH-1:0]       reload_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  input  logic                   irq_ack_i,
  output logic [WIDTH-1:0]       count_o,
  output logic                   busy_o,
  output logic                   expire_o,
  output logic                   irq_o,
  output logic                   missed_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]       CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic [WIDTH-1:0]       reload_q, reload_d;
  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   mode_q, mode_d;
  logic                   expire_q, expire_d;
  logic                   irq_q, irq_d;
  logic                   missed_q, missed_d;
  logic                   tick;
  logic                   expiry;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    presc_cnt_d = presc_cnt_q;
    presc_d     = presc_q;
    mode_d      = mode_q;
    tick        = 1'b0;
    expiry      = 1'b0;

    if (stop_i) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      presc_cnt_d = '0;
    end else if (start_i) begin
      state_d     = ST_RUN;
      count_d     = reload_i;
      reload_d    = reload_i;
      presc_d     = presc_i;
      mode_d      = mode_i;
      presc_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          tick = (presc_cnt_q == presc_q);
          presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_ONE;
          if (tick) begin
            if (count_q != '0) begin
              count_d = count_q - CNT_ONE;
            end else begin
              expiry = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                state_d = ST_DONE;
                count_d = '0;
              end
            end
          end
          // The edge that sees pause still counts; a one-shot that just expired goes to DONE instead.
          if (pause_i && state_d == ST_RUN) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!pause_i) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end

    expire_d = expiry;
    irq_d    = expiry | (irq_q & ~irq_ack_i);
    missed_d = ~irq_ack_i & (missed_q | (expiry & irq_q));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      presc_cnt_q <= '0;
      presc_q     <= '0;
      mode_q      <= 1'b0;
      expire_q    <= 1'b0;
      irq_q       <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      presc_cnt_q <= presc_cnt_d;
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      expire_q    <= expire_d;
      irq_q       <= irq_d;
      missed_q    <= missed_d;
    end
  end

  assign count_o  = count_q;
  assign busy_o   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign expire_o = expire_q;
  assign irq_o    = irq_q;
  assign missed_o = missed_q;

endmodule
